// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: serial nibble adder controller.
// Adds two W-bit operands plus a carry-in, W = 4*N_NIBBLES, using a single
// 4-bit adder. The adder takes one nibble per cycle, least-significant nibble
// first. A ready/valid handshake is used on both the input and output sides.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   operand set presented on a/b/cin
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       W-bit operands
//   cin        carry into the least-significant nibble
//   abort      synchronous cancel of an operation in RUN or DONE
//   out_valid  result available on sum/cout
//   out_ready  consumer accepts the result
//   sum        (a + b + cin) mod 2^W
//   cout       carry out of the most-significant nibble
//   busy       high while nibbles are being added
module add_seq_ctrl #(
    parameter int unsigned N_NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [4*N_NIBBLES-1:0] a,
    input  logic [4*N_NIBBLES-1:0] b,
    input  logic                   cin,
    input  logic                   abort,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [4*N_NIBBLES-1:0] sum,
    output logic                   cout,
    output logic                   busy
);

    localparam int unsigned W     = 4 * N_NIBBLES;
    localparam int unsigned IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic               accept;
    logic               step;
    logic               last_nib;

    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [IDX_W-1:0]   nib_idx;

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         nib_sum;
    logic               nib_cout;

    // Nibble select of the latched operands
    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int unsigned k = 0; k < N_NIBBLES; k++) begin
            if (nib_idx == IDX_W'(k)) begin
                a_nib = a_q[4*k +: 4];
                b_nib = b_q[4*k +: 4];
            end
        end
    end

    // The only adder in the block; every result bit passes through it
    add4 u_add4 (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    assign last_nib = (nib_idx == IDX_W'(N_NIBBLES - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and datapath strobes; abort in IDLE falls through to acceptance
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_nx = IDLE;
                end else begin
                    step = 1'b1;
                    if (last_nib) begin
                        state_nx = DONE;
                    end
                end
            end
            DONE: begin
                if (abort || out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Handshake/status flags follow the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_nx == IDLE);
            out_valid <= (state_nx == DONE);
            busy      <= (state_nx == RUN);
        end
    end

    // Operand latch, carry chain and nibble-wise result write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            nib_idx <= '0;
            sum     <= '0;
        end else if (accept) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            nib_idx <= '0;
        end else if (step) begin
            carry_q <= nib_cout;
            nib_idx <= nib_idx + IDX_W'(1);
            for (int unsigned k = 0; k < N_NIBBLES; k++) begin
                if (nib_idx == IDX_W'(k)) begin
                    sum[4*k +: 4] <= nib_sum;
                end
            end
        end
    end

    // After the last nibble the carry register holds the final carry
    assign cout = carry_q;

endmodule

// add4: 4-bit ripple adder cell used by add_seq_ctrl.
// Ports: a, b 4-bit addends; cin carry in; sum 4-bit result; cout carry out.
module add4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed checks of add_seq_ctrl at N_NIBBLES=4, then
// random vectors against an (a+b+cin) golden model for N_NIBBLES 1, 4 and 8.
module tb_add_seq_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    bit           go = 1'b0;

    int unsigned  n_cmp = 0;
    int unsigned  n_mis = 0;

    always #5 clk = ~clk;

    add_seq_ctrl #(.N_NIBBLES(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .abort     (abort),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present operands for one edge; returns at the negedge after acceptance
    task automatic send(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        @(negedge clk);
        check("send_in_ready", 64'(in_ready), 64'd1);
        a        = va;
        b        = vb;
        cin      = vc;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        abort    = 1'b0;
    endtask

    // Busy for exactly N cycles, then out_valid; optionally disturb inputs in RUN
    task automatic wait_done(input string tag, input bit scramble);
        for (int j = 1; j <= int'(N); j++) begin
            if (j > 1) @(negedge clk);
            if (scramble && j == 1) begin
                a   = 16'hAAAA;
                b   = 16'hAAAA;
                cin = ~cin;
            end
            check($sformatf("%s_busy_c%0d", tag, j), 64'(busy), 64'd1);
            check($sformatf("%s_ovld_c%0d", tag, j), 64'(out_valid), 64'd0);
            check($sformatf("%s_irdy_c%0d", tag, j), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        check({tag, "_ovld_done"}, 64'(out_valid), 64'd1);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] es, input logic ec);
        check({tag, "_sum"}, 64'(sum), 64'(es));
        check({tag, "_cout"}, 64'(cout), 64'(ec));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ovld"}, 64'(out_valid), 64'd0);
        check({tag, "_irdy"}, 64'(in_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_idle({tag, "_rel"});
    endtask

    // Random-vector harnesses for several widths
    for (genvar gi = 0; gi < 3; gi++) begin : g_rand
        localparam int unsigned GN = (gi == 0) ? 1 : (gi == 1) ? 4 : 8;
        localparam int unsigned GW = 4 * GN;

        logic          r_in_valid;
        logic          r_in_ready;
        logic [GW-1:0] r_a;
        logic [GW-1:0] r_b;
        logic          r_cin;
        logic          r_abort;
        logic          r_out_valid;
        logic          r_out_ready;
        logic [GW-1:0] r_sum;
        logic          r_cout;
        logic          r_busy;
        bit            done_flag = 1'b0;

        add_seq_ctrl #(.N_NIBBLES(GN)) u_dut (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (r_in_valid),
            .in_ready  (r_in_ready),
            .a         (r_a),
            .b         (r_b),
            .cin       (r_cin),
            .abort     (r_abort),
            .out_valid (r_out_valid),
            .out_ready (r_out_ready),
            .sum       (r_sum),
            .cout      (r_cout),
            .busy      (r_busy)
        );

        initial begin
            logic [64:0]   tot;
            logic [GW-1:0] e_sum;
            logic          e_cout;
            int            lat;
            r_in_valid  = 1'b0;
            r_out_ready = 1'b0;
            r_abort     = 1'b0;
            r_a         = '0;
            r_b         = '0;
            r_cin       = 1'b0;
            wait (go);
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                check($sformatf("n%0d_irdy_%0d", GN, i), 64'(r_in_ready), 64'd1);
                r_a   = GW'($urandom);
                r_b   = GW'($urandom);
                r_cin = 1'($urandom);
                if (i == 0) begin
                    r_a = '1; r_b = '0; r_cin = 1'b1;
                end else if (i == 1) begin
                    r_a = '1; r_b = '1; r_cin = 1'b1;
                end else if (i == 2) begin
                    r_a = '0; r_b = '0; r_cin = 1'b0;
                end
                tot    = 65'(r_a) + 65'(r_b) + 65'(r_cin);
                e_sum  = tot[GW-1:0];
                e_cout = tot[GW];
                r_in_valid = 1'b1;
                @(negedge clk);
                r_in_valid = 1'b0;
                r_a        = ~r_a;
                r_b        = GW'($urandom);
                r_cin      = ~r_cin;
                lat        = 0;
                while (r_out_valid !== 1'b1 && lat < int'(GN) + 4) begin
                    @(negedge clk);
                    lat++;
                end
                check($sformatf("n%0d_lat_%0d", GN, i), 64'(lat), 64'(GN));
                repeat ($urandom_range(0, 3)) @(negedge clk);
                check($sformatf("n%0d_ovld_%0d", GN, i), 64'(r_out_valid), 64'd1);
                check($sformatf("n%0d_sum_%0d", GN, i), 64'(r_sum), 64'(e_sum));
                check($sformatf("n%0d_cout_%0d", GN, i), 64'(r_cout), 64'(e_cout));
                r_out_ready = 1'b1;
                @(negedge clk);
                r_out_ready = 1'b0;
            end
            done_flag = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        abort     = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;

        // Reset values
        #12;
        check_idle("rst");
        check_result("rst", 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b0;

        // Full carry ripple, latency N
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_done("t1", 1'b0);
        check_result("t1", 16'h0000, 1'b1);
        release_out("t1");

        // Inputs changed mid-RUN, out_ready held high during RUN
        out_ready = 1'b1;
        send(16'h1234, 16'h4321, 1'b1);
        wait_done("t2", 1'b1);
        check_result("t2", 16'h5556, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        check_idle("t2_after");

        // Backpressure in DONE with in_valid asserted
        send(16'h0F0F, 16'h1111, 1'b0);
        wait_done("t3", 1'b0);
        check_result("t3", 16'h2020, 1'b0);
        in_valid = 1'b1;
        a        = 16'hFFFF;
        b        = 16'hFFFF;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("t3_bp_ovld_%0d", j), 64'(out_valid), 64'd1);
            check($sformatf("t3_bp_irdy_%0d", j), 64'(in_ready), 64'd0);
            check_result($sformatf("t3_bp_%0d", j), 16'h2020, 1'b0);
        end
        in_valid = 1'b0;
        release_out("t3");

        // Asynchronous reset during nibble 2
        send(16'h1111, 16'h2222, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("t4_busy_pre", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        check_idle("t4_rst");
        check_result("t4_rst", 16'h0000, 1'b0);
        #1;
        reset = 1'b0;
        send(16'h8000, 16'h8000, 1'b0);
        wait_done("t4", 1'b0);
        check_result("t4", 16'h0000, 1'b1);
        release_out("t4");

        // Abort during nibble 1
        send(16'h1111, 16'h1111, 1'b0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("t5_abort");
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check($sformatf("t5_quiet_%0d", j), 64'(out_valid), 64'd0);
        end

        // Abort together with in_valid in IDLE still accepts
        abort = 1'b1;
        send(16'h0003, 16'h0004, 1'b1);
        wait_done("t6", 1'b0);
        check_result("t6", 16'h0008, 1'b0);
        release_out("t6");

        // Abort in DONE drops the result
        send(16'h00FF, 16'h0001, 1'b0);
        wait_done("t7", 1'b0);
        check_result("t7", 16'h0100, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_idle("t7_abort");

        // Random vectors on all widths in parallel
        go = 1'b1;
        wait (g_rand[0].done_flag && g_rand[1].done_flag && g_rand[2].done_flag);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
